// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect from execute,
// and the fetch-to-decode handshake. master = fetch unit side, slave = environment side.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fd_valid;
    logic [31:0] fd_instruction;
    logic [31:0] fd_pc;
    logic        fd_ready;

    modport master (
        output imem_req_valid, imem_req_addr, fd_valid, fd_instruction, fd_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, fd_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, fd_valid, fd_instruction, fd_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, fd_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// In-order instruction fetch: PC sequencing, in-flight PC queue, decode buffer and redirect flush.
// Define FETCH_STALL_CNT_EN to add the saturating stall_count output.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]  stall_count
`endif
);
    localparam int          PW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int          CW      = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(BUF_DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [31:0]   ifq_mem [BUF_DEPTH];
    logic [PW-1:0] ifq_wr_q, ifq_wr_d, ifq_rd_q, ifq_rd_d;
    logic [CW-1:0] ifq_cnt_q, ifq_cnt_d;

    logic [31:0]   buf_instr_mem [BUF_DEPTH];
    logic [31:0]   buf_pc_mem    [BUF_DEPTH];
    logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;

    logic [CW:0]   occupancy;
    logic [CW:0]   drop_sum;
    logic          req_fire, rsp_keep, fd_fire, head_vis;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Counting in-flight words against the buffer guarantees every response has a slot.
    assign occupancy          = {1'b0, ifq_cnt_q} + {1'b0, buf_cnt_q};
    assign bus.imem_req_valid = !rst && !bus.redirect_valid && (drop_q == '0) && (occupancy < DEPTH_L);
    assign bus.imem_req_addr  = pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_keep           = bus.imem_rsp_valid && !bus.redirect_valid && (state_q == RUN)
                                && (ifq_cnt_q != '0);

    assign head_vis           = !rst && (buf_cnt_q != '0);
    assign bus.fd_valid       = head_vis && !bus.redirect_valid;
    assign bus.fd_instruction = head_vis ? buf_instr_mem[buf_rd_q] : '0;
    assign bus.fd_pc          = head_vis ? buf_pc_mem[buf_rd_q] : '0;
    assign fd_fire            = bus.fd_valid && bus.fd_ready;

    // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latch).
    always_comb begin
        pc_d      = pc_q;
        state_d   = state_q;
        drop_d    = drop_q;
        ifq_wr_d  = ifq_wr_q;
        ifq_rd_d  = ifq_rd_q;
        ifq_cnt_d = ifq_cnt_q;
        buf_wr_d  = buf_wr_q;
        buf_rd_d  = buf_rd_q;
        buf_cnt_d = buf_cnt_q;
        drop_sum  = {1'b0, drop_q} + {1'b0, ifq_cnt_q};

        if (bus.redirect_valid) begin
            // Everything still owed by memory becomes a response to throw away.
            if (bus.imem_rsp_valid && (drop_sum != '0)) drop_sum = drop_sum - 1'b1;
            pc_d      = bus.redirect_pc & 32'hFFFF_FFFC;
            drop_d    = drop_sum[CW-1:0];
            state_d   = (drop_sum != '0) ? FLUSH : RUN;
            ifq_wr_d  = '0;
            ifq_rd_d  = '0;
            ifq_cnt_d = '0;
            buf_wr_d  = '0;
            buf_rd_d  = '0;
            buf_cnt_d = '0;
        end else begin
            if (req_fire) begin
                pc_d     = pc_q + 32'd4;
                ifq_wr_d = ptr_inc(ifq_wr_q);
            end
            if (rsp_keep) begin
                ifq_rd_d = ptr_inc(ifq_rd_q);
                buf_wr_d = ptr_inc(buf_wr_q);
            end
            if (fd_fire) buf_rd_d = ptr_inc(buf_rd_q);
            ifq_cnt_d = ifq_cnt_q + CW'(req_fire) - CW'(rsp_keep);
            buf_cnt_d = buf_cnt_q + CW'(rsp_keep) - CW'(fd_fire);

            case (state_q)
                RUN:   state_d = RUN;
                FLUSH: begin
                    if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
                    state_d = (drop_d == '0) ? RUN : FLUSH;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            drop_q    <= '0;
            ifq_wr_q  <= '0;
            ifq_rd_q  <= '0;
            ifq_cnt_q <= '0;
            buf_wr_q  <= '0;
            buf_rd_q  <= '0;
            buf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            ifq_wr_q  <= ifq_wr_d;
            ifq_rd_q  <= ifq_rd_d;
            ifq_cnt_q <= ifq_cnt_d;
            buf_wr_q  <= buf_wr_d;
            buf_rd_q  <= buf_rd_d;
            buf_cnt_q <= buf_cnt_d;
        end
    end

    // NOTE: storage arrays are not reset; cleared counts make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (req_fire) ifq_mem[ifq_wr_q] <= pc_q;
        if (rsp_keep) begin
            buf_instr_mem[buf_wr_q] <= bus.imem_rsp_data;
            buf_pc_mem[buf_wr_q]    <= ifq_mem[ifq_rd_q];
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (bus.fd_valid && !bus.fd_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model checked every cycle,
// randomized memory latency/handshakes/redirects/resets, plus directed literal checks.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus();
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] data; int due; } mrsp_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_infl[$];
    ent_t        m_buf[$];
    int          m_drop;
    logic [31:0] m_stall;

    // Memory model and observation logs
    mrsp_t       mem_q[$];
    int          last_due = 0;
    logic [31:0] xfer_log[$];
    logic [31:0] acc_log[$];
    int          first_req = -1;
    int          first_fd  = -1;

    // Stimulus knobs
    int          lat_min = 1, lat_max = 1;
    int          ready_pct = 100, fdr_pct = 100, redir_pct = 0, rst_pct = 0;
    logic        redir_once = 1'b0;
    logic [31:0] redir_target = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    // Compare + model/memory advance, once per cycle on the falling edge
    always @(negedge clk) begin
        bit exp_rv, exp_fv, redir, rspv;
        int lat, due, owed;
        if (rst) begin
            check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
            check("rst_fd_valid", {31'b0, bus.fd_valid}, 32'd0);
            check("rst_fd_instr", bus.fd_instruction, 32'd0);
            check("rst_fd_pc", bus.fd_pc, 32'd0);
            m_pc = RESET_PC;
            m_infl.delete();
            m_buf.delete();
            m_drop  = 0;
            m_stall = '0;
            mem_q.delete();
            xfer_log.delete();
            acc_log.delete();
            first_req = -1;
            first_fd  = -1;
        end else begin
            redir  = bus.redirect_valid;
            rspv   = bus.imem_rsp_valid;
            exp_rv = !redir && (m_drop == 0) && ((m_infl.size() + m_buf.size()) < BUF_DEPTH);
            exp_fv = (m_buf.size() != 0) && !redir;
            check("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_rv});
            check("req_addr", bus.imem_req_addr, m_pc);
            check("fd_valid", {31'b0, bus.fd_valid}, {31'b0, exp_fv});
            if (m_buf.size() != 0) begin
                check("fd_pc", bus.fd_pc, m_buf[0].pc);
                check("fd_instr", bus.fd_instruction, m_buf[0].instr);
            end
`ifdef FETCH_STALL_CNT_EN
            check("stall_count", stall_count, m_stall);
            if (exp_fv && !bus.fd_ready && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
`endif
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                acc_log.push_back(bus.imem_req_addr);
                if (first_req < 0) first_req = cyc;
            end
            if (bus.fd_valid && first_fd < 0) first_fd = cyc;
            if (bus.fd_valid && bus.fd_ready) xfer_log.push_back(bus.fd_pc);

            if (redir) begin
                owed = m_drop + m_infl.size();
                if (rspv && owed > 0) owed--;
                m_drop = owed;
                m_infl.delete();
                m_buf.delete();
                m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (exp_fv && bus.fd_ready) void'(m_buf.pop_front());
                if (rspv) begin
                    if (m_drop > 0) m_drop--;
                    else if (m_infl.size() > 0) m_buf.push_back('{bus.imem_rsp_data, m_infl.pop_front()});
                end
                if (exp_rv && bus.imem_req_ready) begin
                    m_infl.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end

            // Memory: in-order responses, each at least one cycle after its request
            if (rspv && mem_q.size() > 0) void'(mem_q.pop_front());
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                lat = int'($urandom_range(lat_max, lat_min));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{instr_of(bus.imem_req_addr), due});
            end
        end
        cyc++;
    end

    task automatic drive();
        if (rst_pct > 0) rst = (int'($urandom_range(999, 0)) < rst_pct);
        bus.imem_req_ready = (int'($urandom_range(99, 0)) < ready_pct);
        bus.fd_ready       = (int'($urandom_range(99, 0)) < fdr_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_q[0].data;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        if (redir_once) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = redir_target;
            redir_once         = 1'b0;
        end else if (int'($urandom_range(99, 0)) < redir_pct) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                             : $urandom;
        end else begin
            bus.redirect_valid = 1'b0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        #1;
        check("reset_req_valid_lit", {31'b0, bus.imem_req_valid}, 32'd0);
        check("reset_fd_valid_lit", {31'b0, bus.fd_valid}, 32'd0);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        #1;
        check("first_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("first_req_addr", bus.imem_req_addr, RESET_PC);
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redir_once   = 1'b1;
        redir_target = target;
        step(1);
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.fd_ready       = 1'b0;

        // Streaming with a 1-cycle memory
        lat_min = 1; lat_max = 1; ready_pct = 100; fdr_pct = 100; redir_pct = 0; rst_pct = 0;
        do_reset();
        release_rst();
        step(8);
        check("stream_first_fd_latency", 32'(first_fd - first_req), 32'd2);
        check("stream_pc0", qat(xfer_log, 0), 32'h0);
        check("stream_pc1", qat(xfer_log, 1), 32'h4);
        check("stream_pc2", qat(xfer_log, 2), 32'h8);

        // Decode back-pressure: fetch stalls once the buffer is full
        fdr_pct = 0;
        do_reset();
        release_rst();
        step(7);
        #1;
`ifdef FETCH_STALL_CNT_EN
        check("stall_count_5", stall_count, 32'd5);
`endif
        step(2);
        #1;
        check("bp_accepted", 32'(acc_log.size()), 32'd2);
        check("bp_fd_valid", {31'b0, bus.fd_valid}, 32'd1);
        check("bp_fd_pc", bus.fd_pc, 32'h0);
        fdr_pct = 100;
        step(8);
        check("bp_pc0", qat(xfer_log, 0), 32'h0);
        check("bp_pc1", qat(xfer_log, 1), 32'h4);
        check("bp_pc2", qat(xfer_log, 2), 32'h8);

        // Redirect with two requests in flight on a 3-cycle memory
        lat_min = 3; lat_max = 3;
        do_reset();
        release_rst();
        step(1);
        redirect_to(32'h0000_0100);
        xfer_log.delete();
        #1;
        check("redir_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        check("redir_no_fd", {31'b0, bus.fd_valid}, 32'd0);
        step(10);
        check("redir_next_pc", qat(xfer_log, 0), 32'h0000_0100);

        // Unaligned redirect target is word-aligned
        redirect_to(32'h0000_0203);
        xfer_log.delete();
        step(1);
        #1;
        check("align_req_addr", bus.imem_req_addr, 32'h0000_0200);
        step(10);
        check("align_fd_pc", qat(xfer_log, 0), 32'h0000_0200);

        // Address wrap at the top of the address space
        lat_min = 1; lat_max = 1;
        redirect_to(32'hFFFF_FFFC);
        acc_log.delete();
        step(10);
        check("wrap_addr0", qat(acc_log, 0), 32'hFFFF_FFFC);
        check("wrap_addr1", qat(acc_log, 1), 32'h0000_0000);

        // Randomized traffic
        lat_min = 1; lat_max = 4; ready_pct = 70; fdr_pct = 60; redir_pct = 3; rst_pct = 5;
        step(4000);
        lat_min = 1; lat_max = 2; ready_pct = 100; fdr_pct = 95; redir_pct = 2; rst_pct = 2;
        step(3000);
        lat_min = 2; lat_max = 6; ready_pct = 50; fdr_pct = 15; redir_pct = 4; rst_pct = 3;
        step(3000);

        rst_pct = 0;
        rst = 1'b0;
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, sets instruction buffer entries; legal values 2..8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_addr  output  32  fetch byte address, word aligned.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_rsp_valid  input  1  response valid; responses are in request order, latency >= 1 cycle.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  branch/jump redirect from execute.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 fd_valid  output  1  instruction valid to decode.
REQ-013 fd_instruction  output  32  instruction to decode.
REQ-014 fd_pc  output  32  PC of fd_instruction.
REQ-015 fd_ready  input  1  decode accepts; transfer when fd_valid && fd_ready.

Function
REQ-016 Block SHALL hold fetch PC pc_q, in-flight PC queue, instruction buffer (instruction+PC, BUF_DEPTH entries), in-flight count, and drop count.
REQ-017 imem_req_addr SHALL equal pc_q; request accepted when imem_req_valid && imem_req_ready, then pc_q SHALL advance by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 imem_req_valid SHALL be high only when not in reset, redirect_valid low, drop count zero, and (in-flight count + buffer count) < BUF_DEPTH.
REQ-019 Each accepted request SHALL push its address onto the in-flight PC queue.
REQ-020 In state RUN, a response SHALL pop the in-flight queue and write {imem_rsp_data, popped PC} into the buffer.
REQ-021 fd_valid SHALL be (buffer count != 0) && !redirect_valid; fd_instruction/fd_pc SHALL show the buffer head.
REQ-022 Latency: request accepted cycle N, response cycle N+k, fd_valid SHALL assert cycle N+k+1.
REQ-023 A transfer SHALL pop the buffer head; simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-024 Buffer overflow SHALL be impossible by construction of REQ-018; with fd_ready low, fetch SHALL stall after at most BUF_DEPTH words.
REQ-025 States: RUN (drop count zero) and FLUSH (drop count nonzero).
REQ-026 On redirect_valid: buffer and in-flight queue SHALL clear, pc_q <= {redirect_pc[31:2],2'b00}, drop count <= in-flight count minus 1 if a response arrives that cycle, else in-flight count; next state FLUSH if drop count nonzero, else RUN.
REQ-027 Any response arriving in the redirect cycle SHALL be discarded.
REQ-028 In FLUSH, each response SHALL be discarded and decrement drop count; at zero, state SHALL return to RUN and requesting SHALL resume the next cycle.
REQ-029 Redirect during FLUSH SHALL apply REQ-026 with drop count = current drop count plus in-flight count, minus any response arriving that cycle.
REQ-030 Redirect SHALL take priority over a simultaneous transfer; no instruction is delivered in the redirect cycle.

Reset
REQ-031 While rst high: pc_q = RESET_PC, buffer, queue, and counts empty/zero, state RUN, imem_req_valid = 0, fd_valid = 0, fd_instruction = 0, fd_pc = 0.
REQ-032 Reset mid-operation SHALL discard all in-flight and buffered instructions; the memory SHALL drop outstanding responses on reset.
REQ-033 The first request SHALL issue in the first cycle after rst deasserts, with address RESET_PC.

Configuration
REQ-034 Macro FETCH_STALL_CNT_EN defined: output stall_count (32-bit) SHALL increment each cycle fd_valid && !fd_ready, reset to 0, and saturate at 32'hFFFF_FFFF.
REQ-035 Macro FETCH_STALL_CNT_EN undefined: stall_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 Reset release, imem_req_ready=1, 1-cycle memory, fd_ready=1 -> fd_pc sequence 0x0,0x4,0x8, first fd_valid 2 cycles after first request.
REQ-037 fd_ready=0 for 10 cycles -> exactly 2 requests accepted, fd_valid held, fd_pc=0x0 stable; release -> 0x0,0x4,0x8 with no gap or duplicate.
REQ-038 3-cycle latency, 2 in flight, redirect_pc=0x100 -> both stale responses dropped, next fd_pc=0x100.
REQ-039 redirect_pc=0x203 -> imem_req_addr=0x200, fd_pc=0x200.
REQ-040 pc_q=0xFFFF_FFFC -> next request address 0x0000_0000; with FETCH_STALL_CNT_EN, 5 stalled cycles -> stall_count=5.
